// File: rtl/mem_access_ctrl_if.sv
// Bundles the MEM-stage request side and the external SRAM side of mem_access_ctrl.
// master = pipeline/SRAM environment, slave = the controller.
interface mem_access_ctrl_if #(
  parameter int SRAM_AW = 16
);
  logic               MEM_R_en;
  logic               MEM_W_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic               freeze;
  logic [31:0]        rdata;
  logic               busy;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic               sram_we;
  logic               sram_re;
  logic [31:0]        sram_rdata;

  modport master (
    output MEM_R_en, MEM_W_en, addr, wdata, sram_rdata,
    input  freeze, rdata, busy, sram_addr, sram_wdata, sram_we, sram_re
  );

  modport slave (
    input  MEM_R_en, MEM_W_en, addr, wdata, sram_rdata,
    output freeze, rdata, busy, sram_addr, sram_wdata, sram_we, sram_re
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a multi-cycle SRAM: freezes the pipeline while an access runs.
// Optional macro POSTED_WRITE_EN: stores are posted (no freeze) and skip the DONE state.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

`ifdef POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SRAM_AW-1:0] waddr_q, waddr_d;
  logic               we_q, we_d;
  logic               re_q, re_d;

  logic               req;
  logic               is_read;
  logic               freeze;
  logic [31:0]        byte_off;
  logic [SRAM_AW-1:0] word_addr;
  logic               unused_addr_bits;

  assign req       = bus.MEM_R_en | bus.MEM_W_en;
  assign is_read   = bus.MEM_R_en;
  assign byte_off  = bus.addr - 32'(ADDR_BASE);
  assign word_addr = byte_off[SRAM_AW+1:2];
  assign unused_addr_bits = ^{byte_off[31:SRAM_AW+2], byte_off[1:0]};

  // Freeze is combinational so the stage registers hold on the very cycle the request appears.
  always_comb begin
    freeze = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    freeze = is_read | (bus.MEM_W_en & ~POSTED);
        ACCESS:  freeze = (POSTED && op_wr_q) ? req : 1'b1;
        default: freeze = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    re_d    = re_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          op_wr_d = ~is_read;
          waddr_d = word_addr;
          wdata_d = bus.wdata;
          re_d    = is_read;
          we_d    = ~is_read;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          re_d = 1'b0;
          we_d = 1'b0;
          if (!op_wr_q) rdata_d = bus.sram_rdata;
          state_d = (POSTED && op_wr_q) ? IDLE : DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign bus.freeze     = freeze;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rdata      = rdata_q;
  assign bus.sram_addr  = waddr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_re    = re_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a behavioural SRAM and access model.
module tb_mem_access_ctrl;
  localparam int WAIT = 5;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.SRAM_AW(16)) bus ();

  mem_access_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_BASE(BASE), .SRAM_AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External SRAM: unwritten words return a fixed address-derived pattern
  logic [31:0] sram_mem [0:65535];
  bit          written  [0:65535];

  function automatic logic [31:0] init_word(input logic [15:0] wa);
    return {wa ^ 16'h5A5A, ~wa};
  endfunction

  always @(posedge clk) begin
    if (bus.sram_we) begin
      sram_mem[bus.sram_addr] <= bus.sram_wdata;
      written[bus.sram_addr]  <= 1'b1;
    end
  end
  assign bus.sram_rdata = written[bus.sram_addr] ? sram_mem[bus.sram_addr] : init_word(bus.sram_addr);

  // Reference model: memory contents as seen by the program and the last loaded word
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata = '0;
  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [15:0] word_of(input logic [31:0] a);
    return 16'((a - 32'(BASE)) >> 2);
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] wa);
    if (ref_mem.exists(int'(wa))) return ref_mem[int'(wa)];
    return init_word(wa);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    bus.MEM_R_en = 1'b0;
    bus.MEM_W_en = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
  endtask

  // Drives one request (called just after a falling edge) and follows it to the release cycle.
  task automatic run_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [15:0] wa;
    int stall, guard, st_cnt;
    bit addr_bad, strobe_bad, wdata_bad;
    wa = word_of(a);
    bus.MEM_R_en = r;
    bus.MEM_W_en = w;
    bus.addr     = a;
    bus.wdata    = d;
    #1;
    guard = 0;
    while (!bus.freeze && guard < 3) begin
      @(negedge clk); #1;
      guard++;
    end
    stall = 0; st_cnt = 0; addr_bad = 0; strobe_bad = 0; wdata_bad = 0;
    while (bus.freeze && stall < 40) begin
      stall++;
      @(negedge clk); #1;
      if (bus.sram_re || bus.sram_we) begin
        st_cnt++;
        if (bus.sram_addr !== wa) addr_bad = 1;
        if (r) begin
          if (bus.sram_re !== 1'b1 || bus.sram_we !== 1'b0) strobe_bad = 1;
        end else begin
          if (bus.sram_we !== 1'b1 || bus.sram_re !== 1'b0) strobe_bad = 1;
          if (bus.sram_wdata !== d) wdata_bad = 1;
        end
      end
    end
    if (r) ref_rdata = ref_read(wa);
    else   ref_mem[int'(wa)] = d;
    chk("stall_cycles", 32'(stall), 32'(WAIT + 1));
    chk("strobe_cycles", 32'(st_cnt), 32'(WAIT));
    chk("sram_addr", {31'd0, addr_bad}, 32'd0);
    chk("strobe_kind", {31'd0, strobe_bad}, 32'd0);
    chk("sram_wdata", {31'd0, wdata_bad}, 32'd0);
    chk("done_busy", {31'd0, bus.busy}, 32'd1);
    chk("done_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
    chk("done_rdata", bus.rdata, ref_rdata);
  endtask

  // Request still held through DONE: controller must return to IDLE without relaunching.
  task automatic end_op();
    @(negedge clk); #1;
    chk("after_done_busy", {31'd0, bus.busy}, 32'd0);
    chk("after_done_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
    idle_inputs();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_freeze", {31'd0, bus.freeze}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
    chk("rst_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 32'd1032, 32'h1234_5678);
    end_op();
  endtask

  task automatic test_load();
    run_op(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF);
    end_op();
    run_op(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("load_deadbeef", bus.rdata, 32'hDEAD_BEEF);
    end_op();
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b0, 32'd1032, 32'h0);
    run_op(1'b1, 1'b0, 32'd1100, 32'h0);
    run_op(1'b1, 1'b0, 32'd1020, 32'h0);
    end_op();
  endtask

  task automatic test_both();
    run_op(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D);
    end_op();
    run_op(1'b1, 1'b0, 32'd1024, 32'h0);
    end_op();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic r, w;
      logic [31:0] a, d;
      int kind;
      kind = int'($urandom_range(0, 2));
`ifdef POSTED_WRITE_EN
      kind = 0;
`endif
      r = (kind != 1);
      w = (kind != 0);
      a = $urandom_range(0, 1) ? 32'(BASE + 4 * $urandom_range(0, 40)) : 32'(BASE - 4 * $urandom_range(1, 40));
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      run_op(r, w, a, d);
      end_op();
    end
  endtask

  task automatic test_reset_mid_access();
    bus.MEM_R_en = 1'b1;
    bus.addr     = 32'd1028;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_re_before", {31'd0, bus.sram_re}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
    chk("mid_rst_freeze", {31'd0, bus.freeze}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    ref_rdata = '0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

`ifdef POSTED_WRITE_EN
  task automatic test_posted();
    logic [31:0] d;
    int frz;
    d = $urandom;
    bus.MEM_W_en = 1'b1;
    bus.addr     = 32'd1184;
    bus.wdata    = d;
    #1;
    chk("posted_store_freeze", {31'd0, bus.freeze}, 32'd0);
    @(negedge clk); #1;
    chk("posted_we", {31'd0, bus.sram_we}, 32'd1);
    bus.MEM_W_en = 1'b0;
    bus.MEM_R_en = 1'b1;
    bus.wdata    = '0;
    #1;
    frz = 0;
    while (bus.freeze && frz < 40) begin
      frz++;
      @(negedge clk); #1;
    end
    ref_mem[int'(word_of(32'd1184))] = d;
    ref_rdata = d;
    chk("posted_load_freeze", 32'(frz), 32'(WAIT + WAIT + 1));
    chk("posted_raw_rdata", bus.rdata, d);
    end_op();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_both();
    test_random();
    test_reset_mid_access();
`ifdef POSTED_WRITE_EN
    test_posted();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
